// File: rtl/miso_drr_sched.sv
// miso_drr_sched: deficit round-robin scheduler granting one of CHANNEL_NUM packet channels at a time
// Ports: clock/reset (sync, active-high); req/head_len per-channel request and head packet length;
// grant/grant_chan/grant_valid registered grant offer; grant_ack accepts it; pkt_done ends the packet;
// busy is high outside IDLE.
module miso_drr_sched #(
    parameter int CHANNEL_NUM = 4,
    parameter int LEN_WIDTH = 8,
    parameter int CNT_WIDTH = 10,
    parameter int QUANTUM = 64,
    localparam int PW = $clog2(CHANNEL_NUM)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNEL_NUM-1:0]         req,
    input  logic [CHANNEL_NUM*LEN_WIDTH-1:0] head_len,
    output logic [CHANNEL_NUM-1:0]         grant,
    output logic [PW-1:0]                  grant_chan,
    output logic                           grant_valid,
    input  logic                           grant_ack,
    input  logic                           pkt_done,
    output logic                           busy
);
    if (CNT_WIDTH < LEN_WIDTH + 1) begin : g_bad_cnt
        $error("CNT_WIDTH must be at least LEN_WIDTH+1");
    end
    if (QUANTUM < 1 || QUANTUM > 2**LEN_WIDTH - 1) begin : g_bad_quantum
        $error("QUANTUM must be in 1..2^LEN_WIDTH-1");
    end

    typedef enum logic [1:0] {IDLE, SCAN, GRANT, WAIT_DONE} state_t;

    state_t                 state, state_n;
    logic [PW-1:0]          ptr, ptr_n, ptr_inc;
    logic                   credited, cred_n;
    logic [LEN_WIDTH-1:0]   len_q, len_n, cur_len, eff_len;
    logic [CNT_WIDTH-1:0]   deficit [CHANNEL_NUM];
    logic [CNT_WIDTH-1:0]   cur_def, def_n, sat;
    logic [CNT_WIDTH:0]     sum;

    always_comb begin
        cur_def = deficit[ptr];
        cur_len = head_len[ptr*LEN_WIDTH +: LEN_WIDTH];
        eff_len = (cur_len == '0) ? LEN_WIDTH'(1) : cur_len;
        sum = {1'b0, cur_def} + (CNT_WIDTH+1)'(QUANTUM);
        sat = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        ptr_inc = (ptr == PW'(CHANNEL_NUM-1)) ? '0 : ptr + 1'b1;
        state_n = state;
        ptr_n = ptr;
        cred_n = credited;
        len_n = len_q;
        def_n = cur_def;
        case (state)
            IDLE: state_n = (|req) ? SCAN : IDLE;
            SCAN: begin
                if (!(|req)) begin
                    def_n = '0;
                    cred_n = 1'b0;
                    state_n = IDLE;
                end else if (!req[ptr]) begin
                    def_n = '0;
                    ptr_n = ptr_inc;
                    cred_n = 1'b0;
                end else if (!credited) begin
                    def_n = sat;
                    cred_n = 1'b1;
                end else if (cur_def >= CNT_WIDTH'(eff_len)) begin
                    len_n = eff_len;
                    state_n = GRANT;
                end else begin
                    ptr_n = ptr_inc;
                    cred_n = 1'b0;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    def_n = cur_def - CNT_WIDTH'(len_q);
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: state_n = pkt_done ? SCAN : WAIT_DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            credited <= 1'b0;
            len_q <= '0;
            for (int i = 0; i < CHANNEL_NUM; i++) deficit[i] <= '0;
            grant <= '0;
            grant_chan <= '0;
            grant_valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            credited <= cred_n;
            len_q <= len_n;
            deficit[ptr] <= def_n;
            grant <= (state_n == GRANT) ? (CHANNEL_NUM'(1) << ptr_n) : '0;
            grant_chan <= (state_n == GRANT) ? ptr_n : grant_chan;
            grant_valid <= (state_n == GRANT);
        end
    end

    assign busy = (state != IDLE);
endmodule
